// File: rtl/armleocpu_csr_pkg.sv
// Shared CSR interface definitions: register-file command encoding and Zicsr funct3 values.
package armleocpu_csr_pkg;

    localparam int ARMLEOCPU_CSR_CMD_WIDTH = 4;

    localparam logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] ARMLEOCPU_CSR_CMD_NONE       = 4'd0;
    localparam logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] ARMLEOCPU_CSR_CMD_WRITE      = 4'd1;
    localparam logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] ARMLEOCPU_CSR_CMD_READ       = 4'd2;
    localparam logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] ARMLEOCPU_CSR_CMD_READ_WRITE = 4'd3;

    localparam logic [2:0] CSR_F3_CSRRW  = 3'b001;
    localparam logic [2:0] CSR_F3_CSRRS  = 3'b010;
    localparam logic [2:0] CSR_F3_CSRRC  = 3'b011;
    localparam logic [2:0] CSR_F3_CSRRWI = 3'b101;
    localparam logic [2:0] CSR_F3_CSRRSI = 3'b110;
    localparam logic [2:0] CSR_F3_CSRRCI = 3'b111;

    // 000 and 100 are the only funct3 values in the SYSTEM opcode that are not Zicsr.
    function automatic logic csr_f3_illegal(input logic [2:0] funct3);
        return funct3[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/armleocpu_csr_alu.sv
// Combinational new-value computation for CSR write/set/clear.
module armleocpu_csr_alu
    import armleocpu_csr_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_old,
    input  logic [31:0] i_src,
    output logic [31:0] o_new
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        o_new = i_src;
        case (i_funct3)
            CSR_F3_CSRRS, CSR_F3_CSRRSI: o_new = i_old | i_src;
            CSR_F3_CSRRC, CSR_F3_CSRRCI: o_new = i_old & ~i_src;
            default:                     o_new = i_src;
        endcase
    end

endmodule

// File: rtl/armleocpu_csr_exec.sv
// Execute-stage Zicsr sequencer: turns CSRRW/RS/RC(I) into register-file commands,
// splitting set/clear into a READ then WRITE read-modify-write.
module armleocpu_csr_exec
    import armleocpu_csr_pkg::*;
#(
    parameter int CMD_WIDTH = ARMLEOCPU_CSR_CMD_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_funct3,
    input  logic [11:0]          req_csr_address,
    input  logic [4:0]           req_rs1_index,
    input  logic [31:0]          req_rs1_value,
    input  logic [4:0]           req_rd,

    output logic [CMD_WIDTH-1:0] csr_cmd,
    output logic [11:0]          csr_address,
    output logic [31:0]          csr_writedata,
    input  logic [31:0]          csr_readdata,
    input  logic                 csr_invalid,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_illegal,
    output logic                 rsp_rd_write,
    output logic [4:0]           rsp_rd_addr,
    output logic [31:0]          rsp_rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        SINGLE,
        RMW_READ,
        RMW_WRITE,
        RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_funct3;
    logic [11:0] r_address;
    logic [4:0]  r_rs1_index;
    logic [4:0]  r_rd;
    logic [31:0] r_src;
    logic [31:0] r_old;
    logic        r_illegal;

    logic [31:0]          w_src;
    logic [31:0]          w_alu_new;
    logic [CMD_WIDTH-1:0] w_single_cmd;

    assign w_src = req_funct3[2] ? {27'b0, req_rs1_index} : req_rs1_value;

    armleocpu_csr_alu u_alu (
        .i_funct3 (r_funct3),
        .i_old    (r_old),
        .i_src    (r_src),
        .o_new    (w_alu_new)
    );

    // Set/clear with x0/zimm=0 must not write, so it degrades to a plain READ.
    always_comb begin
        w_single_cmd = CMD_WIDTH'(ARMLEOCPU_CSR_CMD_READ);
        if (r_funct3[1:0] == 2'b01)
            w_single_cmd = (r_rd == 5'd0) ? CMD_WIDTH'(ARMLEOCPU_CSR_CMD_WRITE)
                                          : CMD_WIDTH'(ARMLEOCPU_CSR_CMD_READ_WRITE);
    end

    always_comb begin
        w_state_nxt   = r_state;
        req_ready     = 1'b0;
        csr_cmd       = CMD_WIDTH'(ARMLEOCPU_CSR_CMD_NONE);
        csr_address   = 12'd0;
        csr_writedata = 32'd0;
        rsp_valid     = 1'b0;
        rsp_illegal   = 1'b0;
        rsp_rd_write  = 1'b0;
        rsp_rd_addr   = 5'd0;
        rsp_rd_data   = 32'd0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (csr_f3_illegal(req_funct3))
                        w_state_nxt = RESP;
                    else if (req_funct3[1:0] == 2'b01 || req_rs1_index == 5'd0)
                        w_state_nxt = SINGLE;
                    else
                        w_state_nxt = RMW_READ;
                end
            end
            SINGLE: begin
                csr_cmd       = w_single_cmd;
                csr_address   = r_address;
                csr_writedata = r_src;
                w_state_nxt   = RESP;
            end
            RMW_READ: begin
                csr_cmd     = CMD_WIDTH'(ARMLEOCPU_CSR_CMD_READ);
                csr_address = r_address;
                w_state_nxt = csr_invalid ? RESP : RMW_WRITE;
            end
            RMW_WRITE: begin
                csr_cmd       = CMD_WIDTH'(ARMLEOCPU_CSR_CMD_WRITE);
                csr_address   = r_address;
                csr_writedata = w_alu_new;
                w_state_nxt   = RESP;
            end
            RESP: begin
                rsp_valid    = 1'b1;
                rsp_illegal  = r_illegal;
                rsp_rd_write = !r_illegal && (r_rd != 5'd0);
                rsp_rd_addr  = r_rd;
                rsp_rd_data  = r_illegal ? 32'd0 : r_old;
                if (rsp_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_state_nxt;
    end

    // csr_readdata/csr_invalid are only meaningful in the cycle their command is driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_funct3    <= 3'd0;
            r_address   <= 12'd0;
            r_rs1_index <= 5'd0;
            r_rd        <= 5'd0;
            r_src       <= 32'd0;
            r_old       <= 32'd0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_funct3    <= req_funct3;
                    r_address   <= req_csr_address;
                    r_rs1_index <= req_rs1_index;
                    r_rd        <= req_rd;
                    r_src       <= w_src;
                    r_old       <= 32'd0;
                    r_illegal   <= csr_f3_illegal(req_funct3);
                end
                SINGLE, RMW_READ: begin
                    r_old     <= csr_readdata;
                    r_illegal <= csr_invalid;
                end
                RMW_WRITE: r_illegal <= csr_invalid;
                default: ;
            endcase
        end
    end

endmodule
